// File: rtl/seg_scan_if.sv
// seg_scan_if: bus between a display host and seg_scan_ctrl.
//   digit_en  per-digit enable (host -> ctrl)
//   value_in  hex nibble per digit, digit i in [4i+3:4i] (host -> ctrl)
//   load      request to latch value_in at the next frame start (host -> ctrl)
//   load_ack  one-cycle pulse when value_in has been latched (ctrl -> host)
//   an        active-low anode selects (ctrl -> pins)
//   seg       active-low segments {g,f,e,d,c,b,a} (ctrl -> pins)
//   frame     one-cycle pulse at each frame start (ctrl -> host)
interface seg_scan_if #(
   parameter int unsigned DIGITS = 4
);
   logic [DIGITS-1:0]   digit_en;
   logic [4*DIGITS-1:0] value_in;
   logic                load;
   logic                load_ack;
   logic [DIGITS-1:0]   an;
   logic [6:0]          seg;
   logic                frame;

   modport master (
      output digit_en, value_in, load,
      input  load_ack, an, seg, frame
   );

   modport slave (
      input  digit_en, value_in, load,
      output load_ack, an, seg, frame
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Cycles through the enabled digits, one slot of SCAN_DIV clocks each, blanking
// the bus for BLANK clocks at slot entry. The display shadow is reloaded from
// value_in only at frame starts, through a load/load_ack handshake.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   seg_scan_if.slave: digit_en, value_in, load in; load_ack, an, seg, frame out
// Build option: define SEG_SCAN_BLANK_EN to enable the per-slot blanking
// interval; without it each digit drives for the full slot.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK    = 500
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);

   localparam int unsigned IW = $clog2(DIGITS);
   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   if (DIGITS < 2 || DIGITS > 8 || SCAN_DIV < 4 || BLANK < 1 || BLANK > SCAN_DIV - 2) begin : g_cfg_err
      $error("seg_scan_ctrl: parameter out of range");
   end

`ifdef SEG_SCAN_BLANK_EN
   localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK - 1);
   typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;
   localparam state_t ST_SLOT_START = ST_BLANK;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE} state_t;
   localparam state_t ST_SLOT_START = ST_DRIVE;
`endif

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    pending_q, pending_d;
   logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
   logic [DIGITS-1:0]       an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    frame_q, frame_d;
   logic                    load_ack_q, load_ack_d;

   // Lowest enabled digit index (0 if none enabled).
   function automatic logic [IW-1:0] lowest_en(input logic [DIGITS-1:0] en);
      logic [IW-1:0] r;
      r = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         if (en[i]) r = IW'(i);
      end
      return r;
   endfunction

   // Next enabled digit strictly above cur, wrapping to the lowest enabled.
   function automatic logic [IW-1:0] next_en(input logic [DIGITS-1:0] en,
                                             input logic [IW-1:0]     cur);
      logic [IW-1:0] r;
      logic          found;
      r     = lowest_en(en);
      found = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (!found && en[i] && (i > int'(cur))) begin
            r     = IW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Hex nibble to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // State, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         pending_q  <= 1'b0;
         shadow_q   <= '0;
         an_q       <= '1;
         seg_q      <= 7'h7F;
         frame_q    <= 1'b0;
         load_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         pending_q  <= pending_d;
         shadow_q   <= shadow_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         frame_q    <= frame_d;
         load_ack_q <= load_ack_d;
      end
   end

   // Next-state, shadow load and output decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      pending_d  = pending_q | bus.load;
      shadow_d   = shadow_q;
      frame_d    = 1'b0;
      load_ack_d = 1'b0;
      an_d       = '1;
      seg_d      = 7'h7F;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|bus.digit_en) begin
               idx_d   = lowest_en(bus.digit_en);
               state_d = ST_SLOT_START;
               frame_d = 1'b1;
            end
         end
`ifdef SEG_SCAN_BLANK_EN
         ST_BLANK: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_BLANK_LAST) state_d = ST_DRIVE;
         end
`endif
         ST_DRIVE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bus.digit_en == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = next_en(bus.digit_en, idx_q);
                  state_d = ST_SLOT_START;
                  // A wrap (including a lone enabled digit) starts a new frame.
                  frame_d = (idx_d <= idx_q);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Atomic shadow update: only at a frame start, merging any earlier loads.
      if (frame_d && pending_d) begin
         shadow_d   = bus.value_in;
         load_ack_d = 1'b1;
         pending_d  = 1'b0;
      end

      // Drive only while the selected digit is still enabled; a dropped enable
      // blanks the rest of the slot without shortening it.
      if (state_d == ST_DRIVE && bus.digit_en[idx_d]) begin
         an_d[idx_d] = 1'b0;
         seg_d       = hex_seg(shadow_d[idx_d]);
      end
   end

   assign bus.an       = an_q;
   assign bus.seg      = seg_q;
   assign bus.frame    = frame_q;
   assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for seg_scan_ctrl
// (DIGITS=4, SCAN_DIV=10, BLANK=2). Stimulus pushes per-cycle expected
// {an, seg, frame, load_ack} tagged with the cycle they must appear in;
// an independent monitor pops and compares them each cycle.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned SCAN_DIV = 10;
   localparam int unsigned BLANK    = 2;
`ifdef SEG_SCAN_BLANK_EN
   localparam int NB = int'(BLANK);
`else
   localparam int NB = 0;
`endif
   localparam int S = int'(SCAN_DIV);

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       frame;
      logic       ack;
      string      tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   c;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [3:0] an_of   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
   logic [6:0] segabcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};

   seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .BLANK    (BLANK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic push(input int cy, input logic [3:0] an, input logic [6:0] seg,
                       input logic fr, input logic ak, input string tag);
      exp_t x;
      x.cyc = cy; x.an = an; x.seg = seg; x.frame = fr; x.ack = ak; x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic push_blank(input int c0, input int n, input string tag);
      for (int i = 0; i < n; i++) push(c0 + i, 4'b1111, 7'h7F, 1'b0, 1'b0, tag);
   endtask

   // One full slot: NB blank cycles then drive; frame/ack only on its first cycle.
   task automatic push_slot(input int base, input logic [3:0] an, input logic [6:0] seg,
                            input logic fr, input logic ak, input string tag);
      for (int i = 0; i < S; i++) begin
         if (i < NB) push(base + i, 4'b1111, 7'h7F, fr && i == 0, ak && i == 0, tag);
         else        push(base + i, an, seg, fr && i == 0, ak && i == 0, tag);
      end
   endtask

   task automatic wait_to(input int cy);
      while (cyc < cy) @(negedge clk);
   endtask

   // Monitor: cycle index advances on each posedge; outputs sampled 1ns later.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc || bus.an !== e.an || bus.seg !== e.seg ||
                bus.frame !== e.frame || bus.load_ack !== e.ack) begin
               n_bad++;
               $display("FAIL %s cyc %0d: got an=%b seg=%h frame=%b ack=%b, want (cyc %0d) an=%b seg=%h frame=%b ack=%b",
                        e.tag, cyc, bus.an, bus.seg, bus.frame, bus.load_ack,
                        e.cyc, e.an, e.seg, e.frame, e.ack);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: cyc=%0d, %0d expectations pending", cyc, sb.size());
      $fatal(1, "timeout");
   end

   initial begin
      bus.digit_en = '0;
      bus.value_in = '0;
      bus.load     = 1'b0;
      rst          = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state, held and released with nothing enabled.
      c = cyc;
      push_blank(c + 1, 1, "reset_hold");
      wait_to(c + 1);
      rst = 1'b0;
      push_blank(c + 2, 2, "reset_idle");
      wait_to(c + 3);

      // Basic scan of 1234 with a load on IDLE exit; two frames.
      c = cyc;
      bus.digit_en = 4'b1111;
      bus.value_in = 16'h1234;
      bus.load     = 1'b1;
      for (int k = 0; k < 8; k++)
         push_slot(c + 1 + S * k, an_of[k % 4], seg1234[k % 4], k % 4 == 0, k == 0, "scan");
      @(negedge clk);
      bus.load = 1'b0;
      wait_to(c + 8 * S);

      // Skip: only digits 0 and 2, frame only on digit 0.
      c = cyc;
      bus.digit_en = 4'b0101;
      for (int k = 0; k < 4; k++)
         push_slot(c + 1 + S * k, an_of[(k % 2) * 2], seg1234[(k % 2) * 2], k % 2 == 0, 1'b0, "skip");
      wait_to(c + 4 * S);

      // Deferred load mid-frame, held for three cycles, acked once at next frame.
      c = cyc;
      bus.value_in = 16'hABCD;
      push_slot(c + 1,         an_of[0], seg1234[0], 1'b1, 1'b0, "defer_old0");
      push_slot(c + 1 + S,     an_of[2], seg1234[2], 1'b0, 1'b0, "defer_old2");
      push_slot(c + 1 + 2 * S, an_of[0], segabcd[0], 1'b1, 1'b1, "defer_new0");
      push_slot(c + 1 + 3 * S, an_of[2], segabcd[2], 1'b0, 1'b0, "defer_new2");
      wait_to(c + 15);
      bus.load = 1'b1;
      wait_to(c + 18);
      bus.load = 1'b0;
      wait_to(c + 4 * S);

      // All disabled mid-drive: blank rest of slot, IDLE, then re-enable digit 2
      // with a load in the frame-start cycle itself.
      c = cyc;
      for (int i = 0; i < NB + 3; i++) begin
         if (i < NB) push(c + 1 + i, 4'b1111, 7'h7F, i == 0, 1'b0, "dis_pre");
         else        push(c + 1 + i, an_of[0], segabcd[0], i == 0, 1'b0, "dis_pre");
      end
      wait_to(c + NB + 3);
      bus.digit_en = 4'b0000;
      push_blank(c + NB + 4, 11 - NB, "dis_blank");
      wait_to(c + 14);
      bus.digit_en = 4'b0100;
      bus.value_in = 16'h0E00;
      bus.load     = 1'b1;
      push_slot(c + 15,     an_of[2], 7'h06, 1'b1, 1'b1, "reenable");
      push_slot(c + 15 + S, an_of[2], 7'h06, 1'b1, 1'b0, "single_wrap");
      @(negedge clk);
      bus.load = 1'b0;
      wait_to(c + 14 + 2 * S);

      // Reset mid-drive, with load asserted during reset; shadow must clear.
      c = cyc;
      for (int i = 0; i < NB + 2; i++) begin
         if (i < NB) push(c + 1 + i, 4'b1111, 7'h7F, i == 0, 1'b0, "rst_pre");
         else        push(c + 1 + i, an_of[2], 7'h06, i == 0, 1'b0, "rst_pre");
      end
      wait_to(c + NB + 2);
      rst      = 1'b1;
      bus.load = 1'b1;
      push_blank(c + NB + 3, 2, "rst_drive");
      wait_to(c + NB + 4);
      bus.load = 1'b0;
      rst      = 1'b0;
      push_slot(c + NB + 5, an_of[2], 7'h40, 1'b1, 1'b0, "rst_shadow");
      wait_to(c + NB + 4 + S);

      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL leftover: %0d expectations never checked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed seven-segment display scan controller for the piano's front-panel readout. It shares one 7-bit segment bus among up to 8 common-anode digits and cycles through the enabled digits on a fixed slot period. Blanking at slot entry suppresses ghosting. Display values are updated atomically at frame boundaries through a load/ack handshake. It replaces the free-running two-digit select toggle as the single owner of anode and segment pins.

## Interface
- DIGITS, 4: number of digits, 2..8
- SCAN_DIV, 50000: clock cycles per digit slot, ≥ 4
- BLANK, 500: blank cycles at start of each slot, 1..SCAN_DIV-2
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- digit_en  in  DIGITS  per-digit enable; bit i gates digit i
- value_in  in  4*DIGITS  hex nibble per digit; digit i in bits [4i+3:4i]
- load  in  1  request to latch value_in into the display shadow
- load_ack  out  1  one-cycle pulse when the shadow is latched
- an  out  DIGITS  anode select, active-low, at most one bit low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- frame  out  1  one-cycle pulse at each frame start

## Operation
- States: IDLE, BLANK, DRIVE. Slot counter `cnt` runs 0..SCAN_DIV-1. Digit index `idx` has width clog2(DIGITS).
- IDLE:
  - Active while digit_en == 0. `cnt` holds 0, an is all ones, seg = 7'h7F.
  - When digit_en becomes nonzero, the next cycle enters BLANK with idx = lowest enabled digit. This entry is a frame start.
- BLANK (cnt 0..BLANK-1):
  - an is all ones, seg = 7'h7F.
  - Moves to DRIVE when cnt == BLANK-1.
- DRIVE (cnt BLANK..SCAN_DIV-1):
  - an[idx] = 0, and all other an bits are 1.
  - seg = hex decode of shadow nibble idx. Decode values: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (hex, gfedcba).
  - If digit_en[idx] drops mid-slot, the controller outputs blank for the rest of the slot without shortening it.
- Slot end (cnt == SCAN_DIV-1):
  - idx advances to the next enabled digit above idx, wrapping to the lowest enabled digit.
  - If no digit is enabled, go to IDLE. Otherwise go to BLANK with cnt = 0.
  - A wrap (new idx ≤ old idx, including a single enabled digit) is a frame start.
- Load handshake:
  - load sets `pending`.
  - At a frame start cycle, if load or pending is set, the shadow latches the current value_in. In that same cycle load_ack pulses for 1 cycle and pending clears.
  - load is level-insensitive: repeated load before the ack merges into one ack.
  - load asserted in the frame-start cycle itself is latched in that frame start.
- frame pulses once per frame start, including IDLE exit.

## Timing
- an, seg, frame and load_ack are registered. They reflect the state and counter of the same cycle in which the transition is decided, and appear one clock later.
- Slot length is exactly SCAN_DIV cycles: BLANK cycles of blank, then SCAN_DIV-BLANK cycles of drive.
- Frame period is SCAN_DIV × (number of enabled digits). digit_en is sampled only at slot end and IDLE exit, apart from the mid-slot blanking rule.
- Reset values (asynchronous, immediate on rst):
  - State IDLE, cnt = 0, idx = 0, pending = 0, shadow = all zeros.
  - an = all ones, seg = 7'h7F, frame = 0, load_ack = 0.
- Reset during DRIVE blanks the display in the same cycle, with no glitch to another digit.
- Under no condition is more than one an bit low. Outputs are always blank for at least BLANK cycles between two different digits.

## Configuration
- SEG_SCAN_BLANK_EN defined: BLANK state is present as specified above.
- SEG_SCAN_BLANK_EN undefined:
  - The BLANK parameter is ignored and the BLANK state is removed.
  - DRIVE spans the full SCAN_DIV cycles and the anode switches directly between digits at slot end.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=10, BLANK=2, macro defined unless stated.

1. Basic scan. Stimulus: after reset, digit_en=4'b1111, value_in=16'h1234, load for 1 cycle. Required response:
   - frame and load_ack pulse together.
   - Digit 0 drives an=4'b1110 and seg=7'h19 for 8 cycles after 2 blank cycles.
   - Digits then follow in order: an 1101/seg 30, 1011/seg 24, 0111/seg 79, repeating with period 40.
2. Skip. Stimulus: digit_en=4'b0101. Required response:
   - an alternates 1110 and 1011 with a 10-cycle slot.
   - frame pulses every 20 cycles, only on entry to digit 0.
3. Deferred load. Stimulus: load pulse mid-frame with value_in=16'hABCD. Required response:
   - load_ack is not asserted until the next frame start, where it pulses exactly once.
   - Old digits stay displayed until then; digit 0 then shows seg=7'h21.
4. All disabled. Stimulus: digit_en goes to 0 during a DRIVE slot. Required response:
   - Blank for the rest of the slot, then IDLE with an=4'b1111 and seg=7'h7F.
   - Re-enabling bit 2 gives a frame pulse and an=4'b1011 after BLANK cycles.
5. Reset mid-drive. Stimulus: rst asserted during DRIVE. Required response:
   - an=4'b1111, seg=7'h7F and load_ack=0 in the same cycle.
   - The shadow reads zero after release (digit shows seg=7'h40).
6. Macro undefined. Stimulus: same as test 1. Required response:
   - No blank cycles; each digit drives for 10 cycles.
   - an goes directly 1110→1101.
